truth_table_sweeper: RTL and testbench

//  Exhaustive stimulus driver and response collector for the single-output

---
 rtl/truth_table_sweeper.sv | 185 ++++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives every input pattern 0..2^N_IN-1 into a single-output
//               Boolean netlist, captures its y0 response into a 2^N_IN-bit
//               truth table, counts the onset, then streams the table out in
//               OUT_W-bit words over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int N_IN    = 8,
    parameter int OUT_W   = 32,
    parameter int DUT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   x,
    input  logic              y0,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_last,
    output logic [N_IN:0]     ones_cnt
);

    localparam int c_DEPTH  = 1 << N_IN;
    localparam int c_NWORDS = c_DEPTH / OUT_W;
    localparam int c_WIDX_W = (c_NWORDS > 1) ? $clog2(c_NWORDS) : 1;
    localparam int c_WSEL   = 1 << c_WIDX_W;
    localparam int c_DR_W   = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    localparam logic [N_IN-1:0]     c_X_MAX      = {N_IN{1'b1}};
    localparam logic [c_WIDX_W-1:0] c_WIDX_LAST  = c_WIDX_W'(c_NWORDS - 1);
    localparam logic [c_DR_W-1:0]   c_DRAIN_LAST = c_DR_W'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SWEEP  = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;
    localparam logic [1:0] c_STREAM = 2'd3;

    // Reject word widths that do not tile the table evenly.
    if (OUT_W < 1 || (OUT_W & (OUT_W - 1)) != 0 || OUT_W > c_DEPTH) begin : g_bad_params
        $error("truth_table_sweeper: OUT_W must be a power of 2 and <= 2^N_IN");
    end

    logic [1:0]          r_state;
    logic [N_IN-1:0]     r_x;
    logic [c_WIDX_W-1:0] r_widx;
    logic [c_DR_W-1:0]   r_drain;
    logic                r_valid;
    logic                r_done;
    logic [c_DEPTH-1:0]  r_tt;
    logic [N_IN:0]       r_ones;

    logic                w_start_ok;
    logic                w_cap_vld;
    logic [N_IN-1:0]     w_cap_idx;

    // A start arriving in the done cycle belongs to the finished sweep and is dropped.
    assign w_start_ok = (r_state == c_IDLE) && start && !r_done;

    // Capture alignment: pair each y0 sample with the pattern driven DUT_LAT cycles earlier.
    if (DUT_LAT == 0) begin : g_lat0
        assign w_cap_idx = r_x;
        assign w_cap_vld = (r_state == c_SWEEP);
    end else begin : g_latn
        logic [N_IN:0] r_dl [DUT_LAT];

        // Shift {valid, pattern} one stage per cycle alongside the netlist pipeline.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DUT_LAT; i++) begin
                    r_dl[i] <= '0;
                end
            end else begin
                r_dl[0] <= {(r_state == c_SWEEP), r_x};
                for (int i = 1; i < DUT_LAT; i++) begin
                    r_dl[i] <= r_dl[i-1];
                end
            end
        end

        assign w_cap_idx = r_dl[DUT_LAT-1][N_IN-1:0];
        assign w_cap_vld = r_dl[DUT_LAT-1][N_IN];
    end

    // Sequencer: pattern counter, drain timer, word index and handshake tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_x     <= '0;
            r_widx  <= '0;
            r_drain <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_x <= '0;
                    if (w_start_ok) begin
                        r_state <= c_SWEEP;
                    end
                end
                c_SWEEP: begin
                    if (r_x == c_X_MAX) begin
                        if (DUT_LAT == 0) begin
                            r_state <= c_STREAM;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= c_DRAIN;
                            r_drain <= '0;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                c_DRAIN: begin
                    // The last in-flight response lands on the final drain edge.
                    if (r_drain == c_DRAIN_LAST) begin
                        r_state <= c_STREAM;
                        r_valid <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                c_STREAM: begin
                    if (r_valid && rd_ready) begin
                        if (r_widx == c_WIDX_LAST) begin
                            r_state <= c_IDLE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_widx  <= '0;
                            r_x     <= '0;
                        end else begin
                            r_widx <= r_widx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Truth table and onset counter: cleared on an accepted start, written by the capture stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tt   <= '0;
            r_ones <= '0;
        end else if (w_start_ok) begin
            r_tt   <= '0;
            r_ones <= '0;
        end else if (w_cap_vld) begin
            r_tt[w_cap_idx] <= y0;
            if (y0) begin
                r_ones <= r_ones + 1'b1;
            end
        end
    end

    // Word view of the table; padding entries only exist when a single word covers it.
    logic [OUT_W-1:0] w_words [c_WSEL];
    for (genvar k = 0; k < c_WSEL; k++) begin : g_word
        if (k < c_NWORDS) begin : g_real
            assign w_words[k] = r_tt[k*OUT_W +: OUT_W];
        end else begin : g_pad
            assign w_words[k] = '0;
        end
    end

    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;
    assign x        = r_x;
    assign rd_valid = r_valid;
    assign rd_data  = r_valid ? w_words[r_widx] : '0;
    assign rd_last  = r_valid && (r_widx == c_WIDX_LAST);
    assign ones_cnt = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper; one instance
//               with a combinational netlist, one with a 2-cycle registered one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // ---- instance 0: combinational netlist ----
    logic        start0 = 1'b0, rd_ready0 = 1'b0, y0_0;
    logic        busy0, done0, rd_valid0, rd_last0;
    logic [7:0]  x0;
    logic [31:0] rd_data0;
    logic [8:0]  ones0;
    logic [2:0]  mode = 3'd0;

    // ---- instance 1: two-cycle registered parity netlist ----
    logic        start1 = 1'b0, rd_ready1 = 1'b0, y0_1;
    logic        busy1, done1, rd_valid1, rd_last1;
    logic [7:0]  x1;
    logic [31:0] rd_data1;
    logic [8:0]  ones1;
    logic        par_a, par_b;

    truth_table_sweeper #(.N_IN(8), .OUT_W(32), .DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .x(x0), .y0(y0_0), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
        .rd_data(rd_data0), .rd_last(rd_last0), .ones_cnt(ones0)
    );

    truth_table_sweeper #(.N_IN(8), .OUT_W(32), .DUT_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .x(x1), .y0(y0_1), .rd_valid(rd_valid1), .rd_ready(rd_ready1),
        .rd_data(rd_data1), .rd_last(rd_last1), .ones_cnt(ones1)
    );

    // Reference functions: 0 x[0], 1 &x, 2 x[7], 3 const 1, 4 ^x, 5 x[0]&x[1]
    function automatic logic fmodel(input logic [2:0] fn, input logic [7:0] p);
        case (fn)
            3'd0:    return p[0];
            3'd1:    return &p;
            3'd2:    return p[7];
            3'd3:    return 1'b1;
            3'd4:    return ^p;
            3'd5:    return p[0] & p[1];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] word_model(input logic [2:0] fn, input int k);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) w[j] = fmodel(fn, 8'(k*32 + j));
        return w;
    endfunction

    assign y0_0 = fmodel(mode, x0);

    always @(posedge clk) begin
        par_a <= ^x1;
        par_b <= par_a;
    end
    assign y0_1 = par_b;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0] data; logic last; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;

    // Scoreboards: every presented word is compared to the queue head, popped on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid0) begin
                if (q0.size() == 0) check("sb0_unexpected_word", 64'(rd_data0), 64'hDEAD);
                else begin
                    check("sb0_data", 64'(rd_data0), 64'(q0[0].data));
                    check("sb0_last", 64'(rd_last0), 64'(q0[0].last));
                    if (rd_ready0) void'(q0.pop_front());
                end
            end
            if (rd_valid1) begin
                if (q1.size() == 0) check("sb1_unexpected_word", 64'(rd_data1), 64'hDEAD);
                else begin
                    check("sb1_data", 64'(rd_data1), 64'(q1[0].data));
                    check("sb1_last", 64'(rd_last1), 64'(q1[0].last));
                    if (rd_ready1) void'(q1.pop_front());
                end
            end
            if (done0) done_cnt0++;
            if (done1) done_cnt1++;
        end
    end

    typedef struct { logic [2:0] fn; int stall; logic [8:0] ones; bit inject; } vec_t;
    vec_t vecs[6];

    // One full sweep on instance 0; stall 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    task automatic run0(input logic [2:0] fn, input int stall, input logic [8:0] exp_ones, input bit inject);
        int cyc;
        mode = fn;
        for (int k = 0; k < 8; k++) q0.push_back('{data: word_model(fn, k), last: (k == 7)});
        done_cnt0 = 0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        check("busy_first_sweep", 64'(busy0), 64'd1);
        cyc = 0;
        while (!rd_valid0 && cyc < 2000) begin
            if (cyc < 3) check("x_count", 64'(x0), 64'(cyc));
            start0 = inject && (cyc == 100);
            cyc++;
            @(posedge clk); #1;
        end
        start0 = 1'b0;
        check("sweep_cycles", 64'(cyc), 64'd256);
        cyc = 0;
        while (!done0 && cyc < 2000) begin
            case (stall)
                0:       rd_ready0 = 1'b1;
                1:       rd_ready0 = (cyc % 3 == 0);
                default: rd_ready0 = 1'($urandom_range(0, 1));
            endcase
            start0 = inject && (cyc == 2);
            cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= 2000) check("stream_timeout", 64'(cyc), 64'd0);
        rd_ready0 = 1'b0;
        start0 = inject;
        @(posedge clk); #1 start0 = 1'b0;
        check("idle_after_done", 64'(busy0), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt0), 64'd1);
        check("ones_cnt", 64'(ones0), 64'(exp_ones));
        check("words_left", 64'(q0.size()), 64'd0);
        check("x_idle", 64'(x0), 64'd0);
        check("valid_idle", 64'(rd_valid0), 64'd0);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{fn: 3'd0, stall: 0, ones: 9'd128, inject: 1'b0};
        vecs[1] = '{fn: 3'd1, stall: 0, ones: 9'd1,   inject: 1'b0};
        vecs[2] = '{fn: 3'd2, stall: 1, ones: 9'd128, inject: 1'b0};
        vecs[3] = '{fn: 3'd5, stall: 2, ones: 9'd64,  inject: 1'b0};
        vecs[4] = '{fn: 3'd0, stall: 1, ones: 9'd128, inject: 1'b1};
        vecs[5] = '{fn: 3'd3, stall: 2, ones: 9'd256, inject: 1'b0};

        #1;
        check("rst_x",      64'(x0),        64'd0);
        check("rst_busy",   64'(busy0),     64'd0);
        check("rst_done",   64'(done0),     64'd0);
        check("rst_valid",  64'(rd_valid0), 64'd0);
        check("rst_last",   64'(rd_last0),  64'd0);
        check("rst_data",   64'(rd_data0),  64'd0);
        check("rst_ones",   64'(ones0),     64'd0);
        check("rst_busy1",  64'(busy1),     64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) run0(vecs[i].fn, vecs[i].stall, vecs[i].ones, vecs[i].inject);

        // Reset in the middle of a sweep, then a clean all-ones sweep.
        mode = 3'd3;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        cyc = 0;
        while (x0 != 8'h5A && cyc < 1000) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("reach_5a", 64'(x0), 64'h5A);
        check("ones_before_rst", 64'(ones0), 64'h5A);
        rst = 1'b1;
        #1;
        check("midrst_x",    64'(x0),    64'd0);
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_ones", 64'(ones0), 64'd0);
        q0.delete();
        @(posedge clk); #1 rst = 1'b0;
        run0(3'd3, 0, 9'd256, 1'b0);

        // Latency-2 instance: registered parity netlist.
        for (int k = 0; k < 8; k++) q1.push_back('{data: word_model(3'd4, k), last: (k == 7)});
        done_cnt1 = 0;
        rd_ready1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        cyc = 0;
        while (!rd_valid1 && cyc < 2000) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("lat2_sweep_cycles", 64'(cyc), 64'd258);
        cyc = 0;
        while (!done1 && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= 200) check("lat2_timeout", 64'(cyc), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("lat2_done_pulses", 64'(done_cnt1), 64'd1);
        check("lat2_ones",        64'(ones1),     64'd128);
        check("lat2_words_left",  64'(q1.size()), 64'd0);
        check("lat2_busy",        64'(busy1),     64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
